// File: rtl/alu_regfile_tensor_core.sv
// Combinational 4-bit ALU, 8x4 register file and a 4x4 signed matrix multiplier
// that runs one inner-product step per clock.
module alu_regfile_tensor_core (
  input  logic                  clock_in,
  input  logic                  reset_in,
  // ALU
  input  logic [7:0]            alu_opcode_in,
  input  logic [3:0]            alu_input1,
  input  logic [3:0]            alu_input2,
  output logic [3:0]            alu_output,
  output logic                  overflow_flag,
  output logic                  carry_flag,
  output logic                  zero_flag,
  output logic                  sign_flag,
  output logic                  parity_flag,
  // Register file
  input  logic                  write_enable_in,
  input  logic [2:0]            write_register_address_in,
  input  logic [3:0]            write_data_in,
  input  logic [2:0]            read_register_address1_in,
  input  logic [2:0]            read_register_address2_in,
  output logic [3:0]            read_data1_out,
  output logic [3:0]            read_data2_out,
  // Tensor core
  input  logic                  tensor_core_register_file_write_enable,
  input  logic [3:0][3:0][3:0]  tensor_core_input1,
  input  logic [3:0][3:0][3:0]  tensor_core_input2,
  output logic [3:0][3:0][3:0]  tensor_core_output,
  output logic                  is_done_with_calculation
);

  localparam logic [7:0] OpAdd    = 8'd0;
  localparam logic [7:0] OpSub    = 8'd1;
  localparam logic [7:0] OpMul    = 8'd2;
  localparam logic [7:0] OpEql    = 8'd3;
  localparam logic [7:0] OpGrt    = 8'd4;
  localparam logic [7:0] OpAddImm = 8'd9;
  localparam logic [7:0] OpSubImm = 8'd10;
  localparam logic [7:0] OpMov    = 8'd11;

  // ---------------------------------------------------------------- ALU
  logic [3:0] alu_res;
  logic       alu_carry;
  logic       alu_ovf;
  logic [4:0] alu_sum;
  logic [3:0] alu_diff;
  logic [7:0] alu_prod;

  always_comb begin
    alu_res   = '0;
    alu_carry = 1'b0;
    alu_ovf   = 1'b0;
    alu_sum   = {1'b0, alu_input1} + {1'b0, alu_input2};
    alu_diff  = alu_input1 - alu_input2;
    // Sign-extended unsigned multiply gives the exact signed product in 8 bits.
    alu_prod  = {{4{alu_input1[3]}}, alu_input1} * {{4{alu_input2[3]}}, alu_input2};
    case (alu_opcode_in)
      OpAdd, OpAddImm: begin
        alu_res   = alu_sum[3:0];
        alu_carry = alu_sum[4];
        alu_ovf   = (alu_input1[3] == alu_input2[3]) && (alu_sum[3] != alu_input1[3]);
      end
      OpSub, OpSubImm: begin
        alu_res   = alu_diff;
        alu_carry = alu_input1 < alu_input2;
        alu_ovf   = (alu_input1[3] != alu_input2[3]) && (alu_diff[3] != alu_input1[3]);
      end
      OpMul: begin
        alu_res   = alu_prod[3:0];
        alu_ovf   = !((alu_prod[7:3] == 5'b00000) || (alu_prod[7:3] == 5'b11111));
        alu_carry = alu_ovf;
      end
      OpEql:   alu_res = {3'b000, alu_input1 == alu_input2};
      OpGrt:   alu_res = {3'b000, $signed(alu_input1) > $signed(alu_input2)};
      OpMov:   alu_res = alu_input1;
      default: alu_res = '0;
    endcase
  end

  always_comb begin
    alu_output    = reset_in ? 4'h0 : alu_res;
    overflow_flag = !reset_in && alu_ovf;
    carry_flag    = !reset_in && alu_carry;
    zero_flag     = !reset_in && (alu_res == 4'h0);
    sign_flag     = !reset_in && alu_res[3];
    parity_flag   = !reset_in && !(^alu_res);
  end

  // ------------------------------------------------------ Register file
  logic [7:0][3:0] regs_q, regs_d;

  always_comb begin
    regs_d = regs_q;
    if (write_enable_in) regs_d[write_register_address_in] = write_data_in;
  end

  always_ff @(posedge clock_in) begin
    if (reset_in) regs_q <= '0;
    else          regs_q <= regs_d;
  end

  // Reads see the pre-edge contents, so a same-cycle write is not forwarded.
  assign read_data1_out = regs_q[read_register_address1_in];
  assign read_data2_out = regs_q[read_register_address2_in];

  // -------------------------------------------------------- Tensor core
  logic [3:0][3:0][9:0] acc_q, acc_d;
  logic [1:0]           k_q, k_d;
  logic                 busy_q, busy_d;
  logic                 done_q, done_d;
  logic [3:0][3:0][3:0] tc_out_q, tc_out_d;

  function automatic logic [9:0] mac_term(input logic [3:0] a, input logic [3:0] b);
    logic [7:0] p;
    p = {{4{a[3]}}, a} * {{4{b[3]}}, b};
    return {{2{p[7]}}, p};
  endfunction

  always_comb begin
    acc_d    = acc_q;
    k_d      = k_q;
    busy_d   = busy_q;
    done_d   = 1'b0;
    tc_out_d = tc_out_q;
    if (tensor_core_register_file_write_enable) begin
      acc_d  = '0;
      k_d    = 2'd0;
      busy_d = 1'b1;
    end else if (busy_q) begin
      for (int i = 0; i < 4; i++) begin
        for (int j = 0; j < 4; j++) begin
          acc_d[i][j] = acc_q[i][j] +
                        mac_term(tensor_core_input1[i][k_q], tensor_core_input2[k_q][j]);
        end
      end
      k_d = k_q + 2'd1;
      if (k_q == 2'd3) begin
        for (int i = 0; i < 4; i++) begin
          for (int j = 0; j < 4; j++) tc_out_d[i][j] = acc_d[i][j][3:0];
        end
        busy_d = 1'b0;
        done_d = 1'b1;
      end
    end
  end

  always_ff @(posedge clock_in) begin
    if (reset_in) begin
      acc_q    <= '0;
      k_q      <= 2'd0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      tc_out_q <= '0;
    end else begin
      acc_q    <= acc_d;
      k_q      <= k_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
      tc_out_q <= tc_out_d;
    end
  end

  assign tensor_core_output       = tc_out_q;
  assign is_done_with_calculation = done_q;

endmodule

// File: tb/tb_alu_regfile_tensor_core.sv
// Self-checking bench: ALU vector table, register-file sequences and tensor-core
// runs checked through expected-value queues.
module tb_alu_regfile_tensor_core;

  typedef logic [3:0][3:0][3:0] mat_t;

  typedef struct {
    logic [7:0] op;
    logic [3:0] a;
    logic [3:0] b;
    logic [3:0] y;
    logic [4:0] flags;  // {overflow, carry, zero, sign, parity}
  } alu_vec_t;

  logic       clock_in;
  logic       reset_in;
  logic [7:0] alu_opcode_in;
  logic [3:0] alu_input1, alu_input2, alu_output;
  logic       overflow_flag, carry_flag, zero_flag, sign_flag, parity_flag;
  logic       write_enable_in;
  logic [2:0] write_register_address_in, read_register_address1_in, read_register_address2_in;
  logic [3:0] write_data_in, read_data1_out, read_data2_out;
  logic       tensor_core_register_file_write_enable;
  mat_t       tensor_core_input1, tensor_core_input2, tensor_core_output;
  logic       is_done_with_calculation;

  int total = 0;
  int bad   = 0;

  alu_vec_t alu_q[$];
  mat_t     mat_q[$];
  alu_vec_t vecs[15];

  alu_regfile_tensor_core dut (
    .clock_in                               (clock_in),
    .reset_in                               (reset_in),
    .alu_opcode_in                          (alu_opcode_in),
    .alu_input1                             (alu_input1),
    .alu_input2                             (alu_input2),
    .alu_output                             (alu_output),
    .overflow_flag                          (overflow_flag),
    .carry_flag                             (carry_flag),
    .zero_flag                              (zero_flag),
    .sign_flag                              (sign_flag),
    .parity_flag                            (parity_flag),
    .write_enable_in                        (write_enable_in),
    .write_register_address_in              (write_register_address_in),
    .write_data_in                          (write_data_in),
    .read_register_address1_in              (read_register_address1_in),
    .read_register_address2_in              (read_register_address2_in),
    .read_data1_out                         (read_data1_out),
    .read_data2_out                         (read_data2_out),
    .tensor_core_register_file_write_enable (tensor_core_register_file_write_enable),
    .tensor_core_input1                     (tensor_core_input1),
    .tensor_core_input2                     (tensor_core_input2),
    .tensor_core_output                     (tensor_core_output),
    .is_done_with_calculation               (is_done_with_calculation)
  );

  initial clock_in = 1'b0;
  always #5 clock_in = ~clock_in;

  initial begin
    #500000;
    $display("FAIL global_timeout act=running exp=finished");
    $fatal(1, "timeout");
  end

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s act=%0h exp=%0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clock_in);
    #1;
  endtask

  function automatic mat_t matmul(input mat_t a, input mat_t b);
    mat_t r;
    for (int i = 0; i < 4; i++) begin
      for (int j = 0; j < 4; j++) begin
        int s;
        s = 0;
        for (int k = 0; k < 4; k++) s += int'($signed(a[i][k])) * int'($signed(b[k][j]));
        r[i][j] = s[3:0];
      end
    end
    return r;
  endfunction

  // Waits for the done pulse after the strobe has been released; returns edges taken.
  task automatic wait_done(output int edges);
    edges = 0;
    for (int c = 1; c <= 10; c++) begin
      tick();
      if (is_done_with_calculation) begin
        edges = c;
        break;
      end
    end
  endtask

  task automatic strobe_tc();
    tensor_core_register_file_write_enable = 1'b1;
    tick();
    tensor_core_register_file_write_enable = 1'b0;
  endtask

  task automatic run_mm(input string name, input mat_t a, input mat_t b);
    int   edges;
    mat_t exp;
    tensor_core_input1 = a;
    tensor_core_input2 = b;
    mat_q.push_back(matmul(a, b));
    strobe_tc();
    wait_done(edges);
    check({name, "_done_latency"}, 64'(edges), 64'd4);
    exp = mat_q.pop_front();
    check({name, "_result"}, tensor_core_output, exp);
    tick();
    check({name, "_done_low"}, 64'(is_done_with_calculation), 64'd0);
    check({name, "_hold"}, tensor_core_output, exp);
  endtask

  initial begin
    mat_t ident, bij, twos, ones, prev;
    alu_vec_t e;
    int edges;
    logic seen_done;

    vecs[0]  = '{8'd0,  4'h7, 4'h1, 4'h8, 5'b10010};
    vecs[1]  = '{8'd1,  4'h3, 4'h5, 4'hE, 5'b01010};
    vecs[2]  = '{8'd2,  4'h3, 4'h3, 4'h9, 5'b11011};
    vecs[3]  = '{8'd3,  4'h5, 4'h5, 4'h1, 5'b00000};
    vecs[4]  = '{8'd4,  4'hF, 4'h2, 4'h0, 5'b00101};
    vecs[5]  = '{8'd9,  4'hF, 4'h1, 4'h0, 5'b01101};
    vecs[6]  = '{8'd10, 4'h8, 4'h1, 4'h7, 5'b10000};
    vecs[7]  = '{8'd11, 4'hA, 4'h3, 4'hA, 5'b00011};
    vecs[8]  = '{8'h55, 4'h7, 4'h7, 4'h0, 5'b00101};
    vecs[9]  = '{8'd4,  4'h2, 4'hF, 4'h1, 5'b00000};
    vecs[10] = '{8'd2,  4'hE, 4'h3, 4'hA, 5'b00011};
    vecs[11] = '{8'd0,  4'h4, 4'h4, 4'h8, 5'b10010};
    vecs[12] = '{8'd3,  4'h5, 4'h4, 4'h0, 5'b00101};
    vecs[13] = '{8'd2,  4'h8, 4'h8, 4'h0, 5'b11101};
    vecs[14] = '{8'h83, 4'h5, 4'h5, 4'h0, 5'b00101};

    reset_in = 1'b1;
    alu_opcode_in = 8'd0; alu_input1 = 4'h7; alu_input2 = 4'h1;
    write_enable_in = 1'b1; write_register_address_in = 3'd3; write_data_in = 4'h7;
    read_register_address1_in = 3'd0; read_register_address2_in = 3'd0;
    tensor_core_register_file_write_enable = 1'b1;
    tensor_core_input1 = '0; tensor_core_input2 = '0;
    tick();
    tick();
    // ALU is forced to zero during reset; reset beats both write strobes.
    check("reset_alu_out", 64'(alu_output), 64'd0);
    check("reset_alu_flags",
          64'({overflow_flag, carry_flag, zero_flag, sign_flag, parity_flag}), 64'd0);
    check("reset_done", 64'(is_done_with_calculation), 64'd0);
    check("reset_tc_out", tensor_core_output, 64'd0);
    reset_in = 1'b0;
    write_enable_in = 1'b0;
    tensor_core_register_file_write_enable = 1'b0;

    // Strobe was held during reset, so the core must stay idle afterwards.
    seen_done = 1'b0;
    for (int c = 0; c < 6; c++) begin
      tick();
      if (is_done_with_calculation) seen_done = 1'b1;
    end
    check("post_reset_idle_no_done", 64'(seen_done), 64'd0);

    // ALU table through the scoreboard queue.
    foreach (vecs[n]) begin
      alu_opcode_in = vecs[n].op;
      alu_input1    = vecs[n].a;
      alu_input2    = vecs[n].b;
      alu_q.push_back(vecs[n]);
      #1;
      e = alu_q.pop_front();
      check($sformatf("alu_out_%0d", n), 64'(alu_output), 64'(e.y));
      check($sformatf("alu_flags_%0d", n),
            64'({overflow_flag, carry_flag, zero_flag, sign_flag, parity_flag}), 64'(e.flags));
    end

    // Register file: all zero after reset (including r3 written during reset).
    for (int r = 0; r < 8; r++) begin
      read_register_address1_in = 3'(r);
      read_register_address2_in = 3'(7 - r);
      #1;
      check($sformatf("rf_reset_r%0d", r), 64'(read_data1_out), 64'd0);
      check($sformatf("rf_reset_p2_r%0d", 7 - r), 64'(read_data2_out), 64'd0);
    end

    tick();
    write_enable_in = 1'b1; write_register_address_in = 3'd5; write_data_in = 4'h6;
    read_register_address1_in = 3'd5; read_register_address2_in = 3'd0;
    #1;
    check("rf_same_cycle_old", 64'(read_data1_out), 64'd0);
    tick();
    write_register_address_in = 3'd0; write_data_in = 4'h9;
    #1;
    check("rf_r5_new", 64'(read_data1_out), 64'd6);
    check("rf_r0_same_cycle_old", 64'(read_data2_out), 64'd0);
    tick();
    write_enable_in = 1'b0;
    #1;
    check("rf_r0_written", 64'(read_data2_out), 64'd9);
    check("rf_r5_kept", 64'(read_data1_out), 64'd6);
    reset_in = 1'b1;
    tick();
    reset_in = 1'b0;
    check("rf_reset_r5", 64'(read_data1_out), 64'd0);
    check("rf_reset_r0", 64'(read_data2_out), 64'd0);

    // Tensor core.
    for (int i = 0; i < 4; i++) begin
      for (int j = 0; j < 4; j++) begin
        ident[i][j] = (i == j) ? 4'h1 : 4'h0;
        bij[i][j]   = 4'(i + j);
        twos[i][j]  = 4'h2;
        ones[i][j]  = 4'h1;
      end
    end

    run_mm("tc_ident", ident, bij);
    check("tc_ident_eq_b", tensor_core_output, bij);
    run_mm("tc_twos", twos, twos);
    check("tc_twos_wrap", tensor_core_output, 64'd0);
    run_mm("tc_ones", ones, ones);
    check("tc_ones_four", tensor_core_output, {16{4'h4}});

    // Idle: new operands do not disturb the held output.
    prev = tensor_core_output;
    tensor_core_input1 = twos;
    tensor_core_input2 = bij;
    seen_done = 1'b0;
    for (int c = 0; c < 5; c++) begin
      tick();
      if (is_done_with_calculation) seen_done = 1'b1;
    end
    check("tc_idle_hold", tensor_core_output, prev);
    check("tc_idle_no_done", 64'(seen_done), 64'd0);

    // Abort at step 2, then a fresh full-length run with different operands.
    tensor_core_input1 = twos;
    tensor_core_input2 = twos;
    strobe_tc();
    seen_done = 1'b0;
    for (int c = 0; c < 2; c++) begin
      tick();
      if (is_done_with_calculation) seen_done = 1'b1;
    end
    tensor_core_input1 = ident;
    tensor_core_input2 = bij;
    mat_q.push_back(matmul(ident, bij));
    strobe_tc();
    check("tc_abort_no_early_done", 64'(seen_done), 64'd0);
    wait_done(edges);
    check("tc_abort_fresh_latency", 64'(edges), 64'd4);
    check("tc_abort_result", tensor_core_output, mat_q.pop_front());

    // A non-trivial signed case against the model.
    for (int i = 0; i < 4; i++) begin
      for (int j = 0; j < 4; j++) begin
        prev[i][j] = 4'($urandom_range(0, 15));
        ident[i][j] = 4'($urandom_range(0, 15));
      end
    end
    run_mm("tc_random", prev, ident);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/alu_regfile_tensor_core.md
ALU_REGFILE_TENSOR_CORE -- requirements
Module: alu_regfile_tensor_core

Interface
REQ-001 SHALL have one clock; reset is synchronous and active-high; ports named clock_in and reset_in.
REQ-002 clock_in  in  1  rising-edge clock for all state.
REQ-003 reset_in  in  1  synchronous active-high reset.
REQ-004 alu_opcode_in  in  8  ALU operation select.
REQ-005 alu_input1, alu_input2  in  4 each  signed two's-complement ALU operands.
REQ-006 alu_output  out  4  signed ALU result.
REQ-007 overflow_flag, carry_flag, zero_flag, sign_flag, parity_flag  out  1 each  ALU status.
REQ-008 write_enable_in  in  1  register-file write strobe.
REQ-009 write_register_address_in  in  3  write index, 0-7.
REQ-010 write_data_in  in  4  signed write data.
REQ-011 read_register_address1_in, read_register_address2_in  in  3 each  read indices.
REQ-012 read_data1_out, read_data2_out  out  4 each  read data.
REQ-013 tensor_core_register_file_write_enable  in  1  operand-change strobe; restarts the matrix multiply.
REQ-014 tensor_core_input1, tensor_core_input2  in  4x4x4  signed matrices A and B, indexed [row][col].
REQ-015 tensor_core_output  out  4x4x4  signed result matrix C.
REQ-016 is_done_with_calculation  out  1  one-cycle completion pulse.

Function
REQ-017 ALU: purely combinational; every result is the low 4 bits of the true result.
REQ-018 ALU opcode 0 ADD and 9 ADD_IMM: a+b; carry = unsigned carry-out of bit 3; overflow = signed overflow.
REQ-019 ALU opcode 1 SUB and 10 SUB_IMM: a-b; carry = unsigned borrow (a<b unsigned); overflow = signed overflow.
REQ-020 ALU opcode 2 MUL: low 4 bits of the signed product; overflow = carry = product outside -8..7.
REQ-021 ALU opcode 3 EQL: output 1 if a==b, else 0.
REQ-022 ALU opcode 4 GRT: output 1 if a>b (signed compare), else 0.
REQ-023 ALU opcode 11 MOV: output = a.
REQ-024 ALU, any other opcode: output 0.
REQ-025 ALU, MOV/EQL/GRT/other opcodes: carry = overflow = 0.
REQ-026 ALU, all opcodes: zero_flag = (output==0); sign_flag = output[3]; parity_flag = 1 when output has an even count of 1 bits.
REQ-027 ALU: while reset_in=1, output and all five flags SHALL be 0.
REQ-028 Register file: 8 x 4-bit registers; reads are asynchronous; the write commits on the rising edge when write_enable_in=1.
REQ-029 Register file: a read of the address being written in the same cycle returns the old value; the new value is visible after the edge.
REQ-030 Register file: every register, including register 0, is writable.
REQ-031 Tensor core state: accumulators acc[4][4] (10-bit signed), step counter k (2-bit), busy flag.
REQ-032 Tensor core, edge with tensor_core_register_file_write_enable=1: acc<=0, k<=0, busy<=1, done<=0.
REQ-033 Tensor core, edge with strobe=0 and busy=1: acc[i][j] += A[i][k]*B[k][j] for all i,j; k<=k+1.
REQ-034 Tensor core: on the edge where k==3, tensor_core_output[i][j] <= low 4 bits of the final sum, busy<=0, and is_done_with_calculation<=1.
REQ-035 Tensor core: is_done_with_calculation is high for exactly one cycle, asserted 4 edges after the strobe is deasserted.
REQ-036 Tensor core idle (busy=0, strobe=0): output holds, done=0, no accumulation.
REQ-037 Tensor core: a strobe while busy aborts and restarts the multiply; no done pulse is issued for the aborted run.
REQ-038 Tensor core: A and B are sampled column/row k at each step, so operands must stay stable while busy.

Reset
REQ-039 On reset_in=1 at an edge: all 8 registers <=0, acc <=0, k <=0, busy <=0, tensor_core_output <=0, done <=0.
REQ-040 Reset has priority over both write strobes.
REQ-041 After reset the tensor core is idle until the next strobe.

Verification
REQ-042 ADD 7+1 -> output -8 (1000), overflow=1, carry=0, sign=1, zero=0, parity=0.
REQ-043 SUB 3-5 -> output -2 (1110), carry=1, overflow=0, parity=0.
REQ-044 MUL 3*3 -> output -7 (1001), overflow=carry=1; EQL 5,5 -> 1; GRT -1,2 -> 0, zero=1, parity=1.
REQ-045 Register file, write r5=6 -> same-cycle read of r5 returns 0 (post-reset), next cycle returns 6; reset -> all reads 0.
REQ-046 Tensor core, A=identity, B[i][j]=i+j, strobe one cycle then low -> done pulse after 4th edge, C=B, done low next cycle, C holds.
REQ-047 Tensor core, A=B=all 2 -> each sum 16 wraps to C=0; A=B=all 1 -> C=all 4; strobe at step 2 -> no done, fresh 4-step run.
